// File: rtl/sdr_tx_pkg.sv
// ---------------------------------------------------------------------------
// sdr_tx_pkg
// Shared types and helpers for the SDR transmit path.
//   state_t     : serializer FSM states
//   T_BIT_ODD   : 1 = T-bit makes data+T hold an odd number of ones
//   PAR_MAX_W   : widest word the parity helper accepts (zero-extend narrower)
//   odd_parity  : T-bit for a data word; also used by the receive-side checker
// ---------------------------------------------------------------------------
package sdr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SHIFT  = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam logic T_BIT_ODD = 1'b1;
  localparam int   PAR_MAX_W = 32;

  // Zero padding does not change the XOR reduction, so callers simply
  // zero-extend their data word to PAR_MAX_W.
  function automatic logic odd_parity(input logic [PAR_MAX_W-1:0] data);
    return T_BIT_ODD ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sdr_tx_serializer.sv
// ---------------------------------------------------------------------------
// sdr_tx_serializer
// Serializes one data byte (MSB first) plus an optional odd-parity T-bit onto
// SDA for SDR write transfers. Bit timing comes from single-cycle SCL edge
// strobes; SDA only changes after a falling-edge strobe.
//
// Ports
//   i_sys_clk        system clock
//   i_rst_n          asynchronous active-low reset
//   i_ser_en         enable from frame FSM; dropping it aborts the frame
//   i_scl_pos_edge   one-cycle SCL rising-edge strobe
//   i_scl_neg_edge   one-cycle SCL falling-edge strobe
//   i_ser_data       byte to send
//   i_ser_valid      i_ser_data valid
//   o_ser_ready      byte accepted this cycle if i_ser_valid is high
//   o_sda            registered serial data
//   o_sda_oe         SDA output enable (0 = released)
//   o_ser_bit_count  bits completed in the current frame
//   o_ser_done       one-cycle pulse at frame completion
//
// state  | meaning
// IDLE   | SDA released, waiting for a byte
// ARMED  | byte captured, waiting for first SCL falling edge
// SHIFT  | driving data bits
// PARITY | driving the T-bit (last-bit state)
// ---------------------------------------------------------------------------
module sdr_tx_serializer
  import sdr_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ser_en,
  input  logic                  i_scl_pos_edge,
  input  logic                  i_scl_neg_edge,
  input  logic [DATA_WIDTH-1:0] i_ser_data,
  input  logic                  i_ser_valid,
  output logic                  o_ser_ready,
  output logic                  o_sda,
  output logic                  o_sda_oe,
  output logic [CNT_WIDTH-1:0]  o_ser_bit_count,
  output logic                  o_ser_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_q,   par_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;
  logic [CNT_WIDTH-1:0]    cnt_q,   cnt_d;
  logic                    sda_q,   sda_d;
  logic                    oe_q,    oe_d;
  logic                    done_q,  done_d;
  logic                    alive_q;

  logic neg;
  logic pos;
  logic last_bit;
  logic ready;
  logic accept;
  logic frame_end;

  // Simultaneous strobes are illegal; the falling edge wins.
  assign neg = i_scl_neg_edge;
  assign pos = i_scl_pos_edge & ~i_scl_neg_edge;

  // Without a T-bit the last-bit slot is SHIFT once the LSB is on the wire.
  assign last_bit = PARITY_EN ? (state_q == PARITY)
                              : ((state_q == SHIFT) && (idx_q == '0));

  // alive_q keeps ready low while reset is asserted, independent of i_ser_en.
  assign ready  = alive_q & i_ser_en &
                  ((state_q == IDLE) | (last_bit & neg));
  assign accept = ready & i_ser_valid;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sda_d     = sda_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    frame_end = 1'b0;

    if ((state_q != IDLE) && !i_ser_en) begin
      // Abort: release the line, keep the count for the frame FSM to inspect.
      state_d = IDLE;
      sda_d   = 1'b1;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d = i_ser_data;
            par_d   = odd_parity(PAR_MAX_W'(i_ser_data));
            cnt_d   = '0;
            state_d = ARMED;
          end
        end

        ARMED: begin
          if (neg) begin
            sda_d   = shreg_q[DATA_WIDTH-1];
            shreg_d = shreg_q << 1;
            idx_d   = IDX_W'(DATA_WIDTH - 1);
            oe_d    = 1'b1;
            state_d = SHIFT;
          end
        end

        SHIFT: begin
          if (pos) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          if (neg) begin
            if (idx_q != '0) begin
              sda_d   = shreg_q[DATA_WIDTH-1];
              shreg_d = shreg_q << 1;
              idx_d   = idx_q - IDX_W'(1);
            end else if (PARITY_EN) begin
              sda_d   = par_q;
              state_d = PARITY;
            end else begin
              frame_end = 1'b1;
            end
          end
        end

        PARITY: begin
          if (pos) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          if (neg) begin
            frame_end = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
          oe_d    = 1'b0;
        end
      endcase

      if (frame_end) begin
        done_d = 1'b1;
        if (accept) begin
          // Back-to-back: the new MSB goes out on the same falling edge,
          // so SDA is never released between frames.
          par_d   = odd_parity(PAR_MAX_W'(i_ser_data));
          sda_d   = i_ser_data[DATA_WIDTH-1];
          shreg_d = i_ser_data << 1;
          idx_d   = IDX_W'(DATA_WIDTH - 1);
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          sda_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sda_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      alive_q <= 1'b1;
    end
  end

  assign o_ser_ready     = ready;
  assign o_sda           = sda_q;
  assign o_sda_oe        = oe_q;
  assign o_ser_bit_count = cnt_q;
  assign o_ser_done      = done_q;

endmodule

// File: tb/tb_sdr_tx_serializer.sv
module tb_sdr_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_en;
  logic       scl_pos;
  logic       scl_neg;
  logic [7:0] ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       sda;
  logic       sda_oe;
  logic [4:0] bit_count;
  logic       ser_done;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  sdr_tx_serializer #(
    .DATA_WIDTH(8),
    .PARITY_EN (1'b1),
    .CNT_WIDTH (5)
  ) dut (
    .i_sys_clk      (clk),
    .i_rst_n        (rst_n),
    .i_ser_en       (ser_en),
    .i_scl_pos_edge (scl_pos),
    .i_scl_neg_edge (scl_neg),
    .i_ser_data     (ser_data),
    .i_ser_valid    (ser_valid),
    .o_ser_ready    (ser_ready),
    .o_sda          (sda),
    .o_sda_oe       (sda_oe),
    .o_ser_bit_count(bit_count),
    .o_ser_done     (ser_done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; inputs change and outputs are sampled
  // 1 time unit after the rising edge.
  task automatic step(input logic n, input logic p);
    scl_neg = n;
    scl_pos = p;
    @(posedge clk);
    #1;
    scl_neg = 1'b0;
    scl_pos = 1'b0;
    if (ser_done === 1'b1) n_done++;
  endtask

  task automatic pos_strobe(output logic b);
    b = sda;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic scl_bit(output logic b);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    pos_strobe(b);
  endtask

  // Accept a byte from IDLE and clock out 8 data bits plus the T-bit,
  // sampling SDA at each rising-edge strobe. Leaves the final falling edge
  // to the caller.
  task automatic send_frame(input logic [7:0] d, output logic [7:0] bits, output logic t);
    logic b;
    bits = '0;
    ser_data  = d;
    ser_valid = 1'b1;
    step(1'b0, 1'b0);
    ser_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      scl_bit(b);
      bits = {bits[6:0], b};
    end
    scl_bit(t);
  endtask

  initial begin
    logic [7:0] bits;
    logic       t;
    logic       b;
    int         done_before;

    rst_n     = 1'b0;
    ser_en    = 1'b1;
    scl_pos   = 1'b0;
    scl_neg   = 1'b0;
    ser_data  = 8'hA5;
    ser_valid = 1'b1;

    // Reset with strobes toggling and a pending byte.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("rst_sda",   32'(sda),       32'd1);
    check("rst_oe",    32'(sda_oe),    32'd0);
    check("rst_count", 32'(bit_count), 32'd0);
    check("rst_ready", 32'(ser_ready), 32'd0);
    check("rst_done",  32'(ser_done),  32'd0);
    ser_valid = 1'b0;
    rst_n     = 1'b1;
    step(1'b0, 1'b0);
    check("idle_ready", 32'(ser_ready), 32'd1);

    // Single frame 0xA5.
    send_frame(8'hA5, bits, t);
    check("a5_bits",  32'(bits),      32'hA5);
    check("a5_t",     32'(t),         32'd1);
    check("a5_count", 32'(bit_count), 32'd9);
    check("a5_oe",    32'(sda_oe),    32'd1);
    check("a5_busy_ready", 32'(ser_ready), 32'd0);
    done_before = n_done;
    step(1'b1, 1'b0);
    check("a5_done",    32'(ser_done), 32'd1);
    check("a5_release", 32'(sda_oe),   32'd0);
    check("a5_sda_hi",  32'(sda),      32'd1);
    step(1'b0, 1'b0);
    check("a5_done_pulse", 32'(n_done - done_before), 32'd1);
    check("a5_count_hold", 32'(bit_count), 32'd9);

    // Parity corners.
    send_frame(8'h00, bits, t);
    check("p00_bits", 32'(bits), 32'h00);
    check("p00_t",    32'(t),    32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    send_frame(8'h01, bits, t);
    check("p01_bits", 32'(bits), 32'h01);
    check("p01_t",    32'(t),    32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    send_frame(8'hFF, bits, t);
    check("pff_bits", 32'(bits), 32'hFF);
    check("pff_t",    32'(t),    32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Back-to-back 0x3C then 0xC3 with valid held throughout.
    done_before = n_done;
    ser_data  = 8'h3C;
    ser_valid = 1'b1;
    step(1'b0, 1'b0);
    ser_data = 8'hC3;
    check("b2b_busy_ready", 32'(ser_ready), 32'd0);
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      scl_bit(b);
      bits = {bits[6:0], b};
    end
    scl_bit(t);
    check("b2b1_bits",  32'(bits),      32'h3C);
    check("b2b1_t",     32'(t),         32'd1);
    check("b2b1_count", 32'(bit_count), 32'd9);
    scl_neg = 1'b1;
    #1;
    check("b2b_lastbit_ready", 32'(ser_ready), 32'd1);
    step(1'b1, 1'b0);
    ser_valid = 1'b0;
    check("b2b_done1",   32'(ser_done),  32'd1);
    check("b2b_oe_held", 32'(sda_oe),    32'd1);
    check("b2b_count0",  32'(bit_count), 32'd0);
    step(1'b0, 1'b0);
    bits = '0;
    pos_strobe(b);
    bits = {bits[6:0], b};
    for (int i = 0; i < 7; i++) begin
      scl_bit(b);
      bits = {bits[6:0], b};
    end
    scl_bit(t);
    check("b2b2_bits",  32'(bits),      32'hC3);
    check("b2b2_t",     32'(t),         32'd1);
    check("b2b2_count", 32'(bit_count), 32'd9);
    step(1'b1, 1'b0);
    check("b2b_release", 32'(sda_oe), 32'd0);
    step(1'b0, 1'b0);
    check("b2b_done_pulses", 32'(n_done - done_before), 32'd2);

    // Abort after 4 bits of 0xF0.
    done_before = n_done;
    ser_data  = 8'hF0;
    ser_valid = 1'b1;
    step(1'b0, 1'b0);
    ser_valid = 1'b0;
    bits = '0;
    for (int i = 0; i < 4; i++) begin
      scl_bit(b);
      bits = {bits[6:0], b};
    end
    check("abort_bits",   32'(bits),      32'h0F);
    check("abort_count4", 32'(bit_count), 32'd4);
    ser_en = 1'b0;
    step(1'b0, 1'b0);
    check("abort_oe",    32'(sda_oe),    32'd0);
    check("abort_sda",   32'(sda),       32'd1);
    check("abort_count", 32'(bit_count), 32'd4);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("abort_count_hold", 32'(bit_count), 32'd4);
    check("abort_no_done", 32'(n_done - done_before), 32'd0);
    ser_en = 1'b1;
    #1;
    check("abort_idle_ready", 32'(ser_ready), 32'd1);

    // Strobe collision mid-frame on 0xA5.
    send_frame(8'hA5, bits, t);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    ser_data  = 8'hA5;
    ser_valid = 1'b1;
    step(1'b0, 1'b0);
    ser_valid = 1'b0;
    bits = '0;
    for (int i = 0; i < 2; i++) begin
      scl_bit(b);
      bits = {bits[6:0], b};
    end
    check("col_count2", 32'(bit_count), 32'd2);
    step(1'b1, 1'b1);
    check("col_no_inc", 32'(bit_count), 32'd2);
    check("col_bit_adv", 32'(sda), 32'd1);
    step(1'b0, 1'b0);
    pos_strobe(b);
    bits = {bits[6:0], b};
    check("col_count3", 32'(bit_count), 32'd3);
    for (int i = 0; i < 5; i++) begin
      scl_bit(b);
      bits = {bits[6:0], b};
    end
    scl_bit(t);
    check("col_bits",  32'(bits),      32'hA5);
    check("col_t",     32'(t),         32'd1);
    check("col_count", 32'(bit_count), 32'd9);
    step(1'b1, 1'b0);
    check("col_done", 32'(ser_done), 32'd1);
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of 0xFF.
    ser_data  = 8'hFF;
    ser_valid = 1'b1;
    step(1'b0, 1'b0);
    ser_valid = 1'b0;
    for (int i = 0; i < 3; i++) scl_bit(b);
    check("arst_pre_oe", 32'(sda_oe), 32'd1);
    #4;
    rst_n = 1'b0;
    #1;
    check("arst_oe",    32'(sda_oe),    32'd0);
    check("arst_sda",   32'(sda),       32'd1);
    check("arst_count", 32'(bit_count), 32'd0);
    check("arst_ready", 32'(ser_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdr_tx_serializer.md
Name: sdr_tx_serializer

Overview:
Transmit-side counterpart of the bit counter: serializes one data byte plus an odd-parity T-bit onto SDA for SDR write transfers.
- Timing comes from single-cycle SCL edge strobes produced by the SCL generator, sampled in the system clock domain.
- Sits between the frame FSM (byte handshake) and the SDA output mux.
- Reports its own bit position so the frame FSM can sequence ACK and T-bit slots.

Parameters:
DATA_WIDTH, 8, data bits per frame, MSB first.
PARITY_EN, 1, 1 = append odd-parity T-bit after the data bits; 0 = data only.
CNT_WIDTH, 5, width of o_ser_bit_count; must hold DATA_WIDTH+1.

Ports:
i_sys_clk  in  1  system clock, 50 MHz.
i_rst_n  in  1  asynchronous active-low reset.
i_ser_en  in  1  block enable from frame FSM; deassertion aborts the frame.
i_scl_pos_edge  in  1  one-cycle strobe, SCL rising edge.
i_scl_neg_edge  in  1  one-cycle strobe, SCL falling edge.
i_ser_data  in  DATA_WIDTH  byte to send.
i_ser_valid  in  1  i_ser_data valid.
o_ser_ready  out  1  block can accept a byte this cycle.
o_sda  out  1  serial data, registered.
o_sda_oe  out  1  SDA output enable; 0 = released (pulled up).
o_ser_bit_count  out  CNT_WIDTH  bits completed in current frame.
o_ser_done  out  1  one-cycle pulse, frame completed.

Behaviour:
- Clock and reset: one clock (i_sys_clk); reset is asynchronous, active-low (i_rst_n).
- Reset values: o_sda=1, o_sda_oe=0, o_ser_ready=0, o_ser_bit_count=0, o_ser_done=0, state=IDLE.
- Handshake: a byte is accepted when i_ser_valid & o_ser_ready at a clock edge.
  - o_ser_ready=1 in IDLE when i_ser_en=1.
  - o_ser_ready=1 in the last-bit state in the cycle i_scl_neg_edge=1, which allows back-to-back frames.
- Capture on accept: shift register <= i_ser_data; parity <= ~^i_ser_data (odd parity, so data plus T holds an odd number of ones).
- States:
  - IDLE: waits for accept, then goes to ARMED.
  - ARMED: waits for i_scl_neg_edge. On it: o_sda <= MSB, o_sda_oe <= 1, go to SHIFT.
  - SHIFT: on each i_scl_neg_edge, drive the next bit. After the LSB has been driven, the next neg edge drives parity and goes to PARITY; if PARITY_EN=0, it goes directly to the end-of-frame handling.
  - PARITY (last-bit state): on i_scl_neg_edge:
    - If a byte is accepted in that cycle: drive its MSB on the same edge, go to SHIFT, pulse o_ser_done.
    - Otherwise: o_sda_oe <= 0, o_sda <= 1, pulse o_ser_done, go to IDLE.
- Data stability: SDA changes only on a neg-edge strobe (plus one register cycle) and is stable across every pos-edge strobe.
- Bit count:
  - Cleared to 0 on accept.
  - Incremented on each i_scl_pos_edge while in SHIFT or PARITY.
  - Reaches DATA_WIDTH+PARITY_EN (9 by default) at frame end and holds until the next accept.
- Latency: first bit on SDA one clock after the first neg strobe following accept; o_ser_done one clock after the final neg strobe.
- Boundary conditions:
  - Pos and neg strobes asserted in the same cycle (illegal): the neg strobe is acted on and the pos strobe is ignored.
  - i_ser_en=0 in any non-IDLE state: next clock o_sda_oe=0, o_sda=1, go to IDLE, count held, no o_ser_done.
  - i_ser_valid while busy (outside the last-bit neg cycle): ignored, o_ser_ready=0.
  - Asynchronous reset mid-frame: all outputs return to reset values immediately.

Decomposition:
- Package sdr_tx_pkg holds:
  - state enum {IDLE, ARMED, SHIFT, PARITY};
  - constant T_BIT_ODD=1;
  - function for odd parity, shared with the receive-side parity checker.
- No sub-module needed. The reusable piece is the shift-register/parity datapath, kept as a function rather than a separate module.

Test Plan:
- Reset: assert i_rst_n=0 for 3 clocks with strobes toggling -> o_sda=1, o_sda_oe=0, count=0, o_ser_ready=0.
- Single frame 0xA5 -> SDA sampled at pos strobes = 1,0,1,0,0,1,0,1, T=1; count ends at 9; one o_ser_done pulse; o_sda_oe drops after the frame.
- Parity corners: 0x00 -> T=1; 0x01 -> T=0; 0xFF -> T=1.
- Back-to-back 0x3C then 0xC3 with valid held -> 18 contiguous bits, no SDA release between frames, two done pulses, count restarts at 0.
- Abort: drop i_ser_en after 4 bits of 0xF0 -> SDA released next clock, no o_ser_done, state IDLE, count stays 4.
- Collision: pos and neg strobes together mid-frame -> bit advances, count does not increment on that cycle.
